// File: rtl/fp_norm_sched128_pkg.sv
// rtl/fp_norm_sched128_pkg.sv - fp128 format widths and normalizer scheduler shared types
//
// Purpose: widths of the fp128 expanded/packed formats, normalizer latency and
//          the record carried alongside each normalizer pipeline stage.
// Ports:   none (package).
package fp_norm_sched128_pkg;

  // fp128 format: 128-bit packed result, 112-bit fraction
  localparam int MSB      = 127;
  localparam int FMSB     = 111;
  // expanded operand is EX+1 bits wide: fraction with guard bits plus widened exponent
  localparam int EX       = MSB + 8;
  localparam int FX       = 2 * FMSB + 3;

  // fpNormalize128 pipeline depth in ce-qualified clocks
  localparam int NORM_LAT = 8;

  // Record fields are sized for the largest supported configuration
  // (NREQ up to 8, TAGW up to 16); narrower configurations use the low bits.
  localparam int ID_MAXW  = 3;
  localparam int TAG_MAXW = 16;

  typedef struct packed {
    logic                vld;
    logic [ID_MAXW-1:0]  id;
    logic [TAG_MAXW-1:0] tag;
  } shadow_t;

endpackage

// File: rtl/fp_rr_arb.sv
// rtl/fp_rr_arb.sv - combinational round-robin pick
//
// Purpose: pick the first asserted request searching circularly from ptr_i.
// Ports:   req_i  request vector
//          ptr_i  index that has highest priority this clock
//          gnt_o  one-hot grant (0 when no request)
//          idx_o  index of the granted request
//          any_o  at least one request present
module fp_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  // Walk from lowest to highest priority so the last hit (closest to ptr) wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr_i) + k) % N;
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_norm_sched128.sv
// rtl/fp_norm_sched128.sv - round-robin scheduler sharing one fpNormalize128 among NREQ units
//
// Purpose: arbitrates requesters onto a single ce-gated normalizer, carries
//          {vld,id,tag} alongside each normalizer stage and returns results
//          tagged with their originator. Output backpressure freezes the
//          whole normalizer via norm_ce.
// Ports:   clk, rst                     clock, synchronous active-high reset
//          req_valid/req_ready          per-requester handshake
//          req_i/req_under/req_tag      per-requester operand, underflow, tag
//          norm_ce/norm_i/norm_under_i  drive to the normalizer
//          norm_o/norm_under_o/norm_inexact  normalizer outputs
//          res_valid/res_ready          result handshake
//          res_o/res_under/res_inexact  result payload (straight from normalizer)
//          res_id/res_tag               originator index and tag
//          busy                         any stage holds a valid op
module fp_norm_sched128
  import fp_norm_sched128_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 4,
  parameter int LAT  = NORM_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*(EX+1)-1:0]     req_i,
  input  logic [NREQ-1:0]            req_under,
  input  logic [NREQ*TAGW-1:0]       req_tag,
  output logic                       norm_ce,
  output logic [EX:0]                norm_i,
  output logic                       norm_under_i,
  input  logic [MSB+3:0]             norm_o,
  input  logic                       norm_under_o,
  input  logic                       norm_inexact,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [MSB+3:0]             res_o,
  output logic                       res_under,
  output logic                       res_inexact,
  output logic [$clog2(NREQ)-1:0]    res_id,
  output logic [TAGW-1:0]            res_tag,
  output logic                       busy
);

  localparam int IW  = $clog2(NREQ);
  localparam int OPW = EX + 1;

  shadow_t          stage_q [LAT];
  shadow_t          stage_d;
  logic [IW-1:0]    ptr_q, ptr_d;

  logic [NREQ-1:0]  gnt_oh;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             adv;
  logic             issue;

  fp_rr_arb #(.N(NREQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // The last stage is the output register: it may only move when empty or consumed.
  assign adv       = !stage_q[LAT-1].vld || res_ready;
  assign issue     = adv && gnt_any && !rst;
  // During reset the normalizer keeps clocking so stale contents flush out.
  assign norm_ce   = adv || rst;
  assign req_ready = issue ? gnt_oh : '0;

  always_comb begin
    stage_d      = '0;
    norm_i       = '0;
    norm_under_i = 1'b0;
    ptr_d        = ptr_q;
    if (issue) begin
      norm_i                = req_i[int'(gnt_idx)*OPW +: OPW];
      norm_under_i          = req_under[gnt_idx];
      stage_d.vld           = 1'b1;
      stage_d.id[IW-1:0]    = gnt_idx;
      stage_d.tag[TAGW-1:0] = req_tag[int'(gnt_idx)*TAGW +: TAGW];
      ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IW'(1);
    end
  end

  // Shadow shift register, advancing in lockstep with the normalizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (adv) begin
        stage_q[0] <= stage_d;
        for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign res_valid   = stage_q[LAT-1].vld;
  assign res_id      = stage_q[LAT-1].id[IW-1:0];
  assign res_tag     = stage_q[LAT-1].tag[TAGW-1:0];
  assign res_o       = norm_o;
  assign res_under   = norm_under_o;
  assign res_inexact = norm_inexact;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LAT; i++) busy = busy | stage_q[i].vld;
  end

endmodule

// File: tb/tb_fp_norm_sched128.sv
// tb/tb_fp_norm_sched128.sv - self-checking bench for fp_norm_sched128
module tb_fp_norm_sched128;
  import fp_norm_sched128_pkg::*;

  localparam int NREQ = 4;
  localparam int TAGW = 4;
  localparam int LAT  = NORM_LAT;
  localparam int IW   = $clog2(NREQ);
  localparam int OPW  = EX + 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*OPW-1:0]    req_i;
  logic [NREQ-1:0]        req_under;
  logic [NREQ*TAGW-1:0]   req_tag;
  logic                   norm_ce;
  logic [EX:0]            norm_i;
  logic                   norm_under_i;
  logic [MSB+3:0]         norm_o;
  logic                   norm_under_o;
  logic                   norm_inexact;
  logic                   res_valid;
  logic                   res_ready;
  logic [MSB+3:0]         res_o;
  logic                   res_under;
  logic                   res_inexact;
  logic [IW-1:0]          res_id;
  logic [TAGW-1:0]        res_tag;
  logic                   busy;

  int n_chk  = 0;
  int n_fail = 0;
  int n_hs   = 0;
  int seq    = 0;

  always #5 clk = ~clk;

  fp_norm_sched128 #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_i(req_i),
    .req_under(req_under), .req_tag(req_tag),
    .norm_ce(norm_ce), .norm_i(norm_i), .norm_under_i(norm_under_i),
    .norm_o(norm_o), .norm_under_o(norm_under_o), .norm_inexact(norm_inexact),
    .res_valid(res_valid), .res_ready(res_ready), .res_o(res_o),
    .res_under(res_under), .res_inexact(res_inexact),
    .res_id(res_id), .res_tag(res_tag), .busy(busy)
  );

  // Behavioural normalizer: LAT-deep ce-gated delay with a simple output mapping.
  logic [EX:0] np_d [LAT];
  logic        np_u [LAT];
  initial for (int i = 0; i < LAT; i++) begin np_d[i] = '0; np_u[i] = 1'b0; end
  always @(posedge clk) if (norm_ce) begin
    np_d[0] <= norm_i;
    np_u[0] <= norm_under_i;
    for (int i = 1; i < LAT; i++) begin np_d[i] <= np_d[i-1]; np_u[i] <= np_u[i-1]; end
  end
  assign norm_o       = np_d[LAT-1][MSB+3:0];
  assign norm_under_o = np_u[LAT-1];
  assign norm_inexact = np_d[LAT-1][EX];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of in-flight ops, each aging one step per advancing clock.
  typedef struct {
    int          id;
    logic [3:0]  tag;
    logic [EX:0] data;
    logic        under;
    int          age;
  } op_t;
  op_t q[$];
  int  ptr_m = 0;

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  function automatic bit m_out_valid();
    return q.size() > 0 && q[0].age == LAT;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      ptr_m = 0;
    end else if (!m_out_valid() || res_ready) begin
      int g;
      op_t o;
      if (m_out_valid()) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      g = pick(req_valid, ptr_m);
      if (g >= 0) begin
        o.id = g; o.tag = req_tag[g*TAGW +: TAGW];
        o.data = req_i[g*OPW +: OPW]; o.under = req_under[g]; o.age = 1;
        q.push_back(o);
        ptr_m = (g + 1) % NREQ;
      end
    end
  end

  always @(negedge clk) begin
    bit adv;
    int g;
    logic [NREQ-1:0] exp_rr;
    adv = !m_out_valid() || res_ready;
    g = pick(req_valid, ptr_m);
    exp_rr = (!rst && adv && g >= 0) ? NREQ'(1) << g : '0;
    chk("norm_ce", norm_ce, rst ? 1'b1 : adv);
    chk("req_ready", req_ready, exp_rr);
    if (!rst) begin
      chk("res_valid", res_valid, m_out_valid());
      chk("busy", busy, q.size() > 0);
      if (adv && g >= 0) begin
        chk("norm_i", norm_i, req_i[g*OPW +: OPW]);
        chk("norm_under_i", norm_under_i, req_under[g]);
      end else begin
        chk("norm_i_idle", norm_i, 0);
      end
      if (m_out_valid()) begin
        chk("res_id", res_id, q[0].id);
        chk("res_tag", res_tag, q[0].tag);
        chk("res_o", res_o, q[0].data[MSB+3:0]);
        chk("res_under", res_under, q[0].under);
        chk("res_inexact", res_inexact, q[0].data[EX]);
      end
      if (res_valid && res_ready) n_hs++;
    end
  end

  // Advance one clock and refresh operand payloads so only the accepting edge matters.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int r = 0; r < NREQ; r++) begin
      logic [EX:0] d;
      d = '0;
      d[31:0]   = ~32'(seq);
      d[63:32]  = 32'(seq);
      d[95:64]  = 32'(seq) ^ 32'hA5A5_0000;
      d[127:96] = 32'(seq * 7 + r);
      d[EX -: 8] = 8'(r) ^ 8'(seq);
      req_i[r*OPW +: OPW] = d;
      req_under[r] = seq[0] ^ r[0];
    end
    seq++;
  endtask

  task automatic set_tag(input int r, input logic [3:0] t);
    req_tag[r*TAGW +: TAGW] = t;
  endtask

  task automatic single_op(input int r, input logic [3:0] t);
    tick();
    req_valid = NREQ'(1) << r;
    set_tag(r, t);
    #1 chk("op_grant", req_ready, NREQ'(1) << r);
    tick();
    req_valid = '0;
    for (int i = 1; i <= LAT; i++) begin
      #1 chk("op_latency", res_valid, i == LAT);
      if (i < LAT) tick();
    end
    chk("op_id", res_id, r);
    chk("op_tag", res_tag, t);
    tick();
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b0; req_valid = '0; req_i = '0; req_under = '0; req_tag = '0;
    repeat (3) tick();
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_norm_ce", norm_ce, 1);
    rst = 1'b0;
    res_ready = 1'b1;

    // 1: single op from requester 0 with tag 5
    single_op(0, 4'd5);

    // 2: all requesters valid from a fresh pointer
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int r = 0; r < NREQ; r++) set_tag(r, 4'(r + 8));
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_rr_order", req_ready, NREQ'(1) << (k % NREQ));
      tick();
    end
    drain(12);

    // 3: stall with three ops in flight
    req_valid = 4'b0001; set_tag(0, 4'd1); tick();
    set_tag(0, 4'd2); tick();
    set_tag(0, 4'd3); tick();
    req_valid = '0; res_ready = 1'b0;
    for (int w = 0; w < 20 && !res_valid; w++) tick();
    chk("t3_arrive", res_valid, 1);
    req_valid = '1;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("t3_ce_low", norm_ce, 0);
      chk("t3_no_grant", req_ready, 0);
      chk("t3_hold_tag", res_tag, 4'd1);
      tick();
    end
    begin
      int h0;
      res_ready = 1'b1; req_valid = '0;
      h0 = n_hs;
      repeat (12) tick();
      chk("t3_count", n_hs - h0, 3);
    end

    // 4: fairness between a hog and a late requester
    req_valid = 4'b0001;
    repeat (3) tick();
    req_valid = 4'b0101;
    begin
      bit got2, prev0, dbl;
      got2 = 0; prev0 = 0; dbl = 0;
      for (int k = 0; k < 6; k++) begin
        #1;
        if (k == 0) chk("t4_first", req_ready, 4'b0100);
        if (k < 2 && req_ready[2]) got2 = 1;
        if (prev0 && req_ready[0]) dbl = 1;
        prev0 = req_ready[0];
        tick();
      end
      chk("t4_req2_soon", got2, 1);
      chk("t4_no_double0", dbl, 0);
    end
    drain(12);

    // 5: reset with six ops in flight
    req_valid = '1;
    repeat (6) tick();
    req_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1 chk("t5_no_stale", res_valid, 0);
      tick();
    end
    single_op(2, 4'hC);
    drain(4);

    // 6: alternating bubbles
    for (int j = 0; j < 18; j++) begin
      req_valid = (j < 8 && j % 2 == 0) ? 4'b0001 : 4'b0000;
      #1;
      chk("t6_valid_pat", res_valid, j >= 8 && j <= 14 && j % 2 == 0);
      chk("t6_busy", busy, j >= 1 && j <= 14);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
